// File: rtl/data_mem_arbiter_if.sv
// Bus bundle between the data-memory arbiter, its two requesters and the memory macro.
interface data_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 11
);
  // Requester 0 (CPU load/store path)
  logic              r0_req;
  logic [3:0]        r0_we;
  logic [ADDR_W-1:0] r0_addr;
  logic [31:0]       r0_wdata;
  logic              r0_ack;
  logic              r0_stall;
  // Requester 1 (auxiliary loader/DMA)
  logic              r1_req;
  logic [3:0]        r1_we;
  logic [ADDR_W-1:0] r1_addr;
  logic [31:0]       r1_wdata;
  logic              r1_ack;
  logic              r1_stall;
  // Shared read data back to the requesters
  logic [31:0]       rdata;
  // Single-port memory side
  logic              mem_en;
  logic [3:0]        mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  r0_req, r0_we, r0_addr, r0_wdata,
    output r0_ack, r0_stall,
    input  r1_req, r1_we, r1_addr, r1_wdata,
    output r1_ack, r1_stall,
    output rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output r0_req, r0_we, r0_addr, r0_wdata,
    input  r0_ack, r0_stall,
    output r1_req, r1_we, r1_addr, r1_wdata,
    input  r1_ack, r1_stall,
    input  rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// Two-requester arbiter for the single-port 2K x 32 data memory.
// Each access runs IDLE -> ACCESS -> (WAIT x N) -> RESP; the CPU is stalled while pending.
module data_mem_arbiter #(
  parameter int unsigned ADDR_W      = 11,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned FIXED_PRIO  = 0
) (
  input  logic              clk,
  input  logic              reset,
  data_mem_arbiter_if.slave bus
);

  localparam logic [3:0] WAIT_LOAD = 4'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } stateT;

  stateT             state;
  logic              owner;
  logic              lastGrant;
  logic [3:0]        waitCnt;
  logic              memEn;
  logic [3:0]        memWe;
  logic [ADDR_W-1:0] memAddr;
  logic [31:0]       memWdata;
  logic              r0Ack;
  logic              r1Ack;

  logic              grantOwner;
  logic [3:0]        selWe;
  logic [ADDR_W-1:0] selAddr;
  logic [31:0]       selWdata;

  // Pick the winner for an IDLE-cycle request and mux its access fields
  always_comb begin
    grantOwner = 1'b0;
    if (bus.r0_req && bus.r1_req) begin
      grantOwner = (FIXED_PRIO != 0) ? 1'b0 : ~lastGrant;
    end else if (bus.r1_req) begin
      grantOwner = 1'b1;
    end
    selWe    = grantOwner ? bus.r1_we    : bus.r0_we;
    selAddr  = grantOwner ? bus.r1_addr  : bus.r0_addr;
    selWdata = grantOwner ? bus.r1_wdata : bus.r0_wdata;
  end

  // Access sequencer; memory strobes and acks are registered so each lands on its own cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      owner     <= 1'b0;
      lastGrant <= 1'b1;
      waitCnt   <= 4'd0;
      memEn     <= 1'b0;
      memWe     <= 4'b0000;
      memAddr   <= '0;
      memWdata  <= 32'd0;
      r0Ack     <= 1'b0;
      r1Ack     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.r0_req || bus.r1_req) begin
            state     <= ACCESS;
            owner     <= grantOwner;
            lastGrant <= grantOwner;
            memEn     <= 1'b1;
            memWe     <= selWe;
            memAddr   <= selAddr;
            memWdata  <= selWdata;
          end
        end
        ACCESS: begin
          memEn <= 1'b0;
          memWe <= 4'b0000;
          if (WAIT_STATES == 0) begin
            state <= RESP;
            r0Ack <= ~owner;
            r1Ack <= owner;
          end else begin
            waitCnt <= WAIT_LOAD;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (waitCnt == 4'd0) begin
            state <= RESP;
            r0Ack <= ~owner;
            r1Ack <= owner;
          end else begin
            waitCnt <= waitCnt - 4'd1;
          end
        end
        RESP: begin
          r0Ack <= 1'b0;
          r1Ack <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Drive the bus; stall and read data must be same-cycle with ack, hence not registered
  assign bus.mem_en    = memEn;
  assign bus.mem_we    = memWe;
  assign bus.mem_addr  = memAddr;
  assign bus.mem_wdata = memWdata;
  assign bus.r0_ack    = r0Ack;
  assign bus.r1_ack    = r1Ack;
  assign bus.r0_stall  = bus.r0_req & ~r0Ack;
  assign bus.r1_stall  = bus.r1_req & ~r1Ack;
  assign bus.rdata     = bus.mem_rdata;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: three instances cover W=0/RR, W=3/RR and W=0/fixed priority.
module tb_data_mem_arbiter;

  localparam int unsigned AW = 11;

  logic clk = 1'b0;
  logic reset;
  int   compared   = 0;
  int   mismatched = 0;

  always #5 clk = ~clk;

  data_mem_arbiter_if #(.ADDR_W(AW)) busA ();
  data_mem_arbiter_if #(.ADDR_W(AW)) busB ();
  data_mem_arbiter_if #(.ADDR_W(AW)) busC ();

  data_mem_arbiter #(.ADDR_W(AW), .WAIT_STATES(0), .FIXED_PRIO(0)) dutA (.clk(clk), .reset(reset), .bus(busA));
  data_mem_arbiter #(.ADDR_W(AW), .WAIT_STATES(3), .FIXED_PRIO(0)) dutB (.clk(clk), .reset(reset), .bus(busB));
  data_mem_arbiter #(.ADDR_W(AW), .WAIT_STATES(0), .FIXED_PRIO(1)) dutC (.clk(clk), .reset(reset), .bus(busC));

  logic [31:0] memA [2048];
  logic [31:0] memB [2048];
  logic [31:0] memC [2048];

  // Synchronous-read, byte-write memory models, one per instance
  always @(posedge clk) begin
    if (busA.mem_en) begin
      for (int b = 0; b < 4; b++)
        if (busA.mem_we[b]) memA[busA.mem_addr][8*b +: 8] <= busA.mem_wdata[8*b +: 8];
      busA.mem_rdata <= memA[busA.mem_addr];
    end
  end

  always @(posedge clk) begin
    if (busB.mem_en) begin
      for (int b = 0; b < 4; b++)
        if (busB.mem_we[b]) memB[busB.mem_addr][8*b +: 8] <= busB.mem_wdata[8*b +: 8];
      busB.mem_rdata <= memB[busB.mem_addr];
    end
  end

  always @(posedge clk) begin
    if (busC.mem_en) begin
      for (int b = 0; b < 4; b++)
        if (busC.mem_we[b]) memC[busC.mem_addr][8*b +: 8] <= busC.mem_wdata[8*b +: 8];
      busC.mem_rdata <= memC[busC.mem_addr];
    end
  end

  task automatic clear_inputs();
    busA.r0_req = 0; busA.r0_we = 0; busA.r0_addr = 0; busA.r0_wdata = 0;
    busA.r1_req = 0; busA.r1_we = 0; busA.r1_addr = 0; busA.r1_wdata = 0;
    busB.r0_req = 0; busB.r0_we = 0; busB.r0_addr = 0; busB.r0_wdata = 0;
    busB.r1_req = 0; busB.r1_we = 0; busB.r1_addr = 0; busB.r1_wdata = 0;
    busC.r0_req = 0; busC.r0_we = 0; busC.r0_addr = 0; busC.r0_wdata = 0;
    busC.r1_req = 0; busC.r1_we = 0; busC.r1_addr = 0; busC.r1_wdata = 0;
  endtask

  // Run one access on instance B; returns ack latency (-1 on timeout), read data and mem_en count
  task automatic access_b(input bit who, input logic [3:0] we, input logic [10:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rd,
                          output int lat, output int enCnt);
    @(negedge clk);
    if (who) begin
      busB.r1_we = we; busB.r1_addr = addr; busB.r1_wdata = wdata; busB.r1_req = 1;
    end else begin
      busB.r0_we = we; busB.r0_addr = addr; busB.r0_wdata = wdata; busB.r0_req = 1;
    end
    lat = -1; enCnt = 0; rd = 32'hx;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (busB.mem_en) enCnt++;
      if ((who ? busB.r1_ack : busB.r0_ack) === 1'b1) begin
        lat = c;
        rd  = busB.rdata;
        break;
      end
    end
    busB.r0_req = 0; busB.r1_req = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    clear_inputs();
    repeat (3) @(negedge clk);
    reset = 0;
    compared++;
    if ({busA.mem_en, busA.mem_we, busA.mem_addr, busA.mem_wdata, busA.r0_ack, busA.r1_ack} !== '0) begin
      mismatched++; $display("FAIL reset_A: got en=%b we=%b addr=%h wd=%h ack=%b%b expected all zero",
        busA.mem_en, busA.mem_we, busA.mem_addr, busA.mem_wdata, busA.r0_ack, busA.r1_ack);
    end
    compared++;
    if ({busB.mem_en, busB.mem_we, busB.mem_addr, busB.mem_wdata, busB.r0_ack, busB.r1_ack} !== '0) begin
      mismatched++; $display("FAIL reset_B: got en=%b we=%b addr=%h wd=%h ack=%b%b expected all zero",
        busB.mem_en, busB.mem_we, busB.mem_addr, busB.mem_wdata, busB.r0_ack, busB.r1_ack);
    end
    compared++;
    if ({busC.mem_en, busC.mem_we, busC.mem_addr, busC.mem_wdata, busC.r0_ack, busC.r1_ack} !== '0) begin
      mismatched++; $display("FAIL reset_C: got en=%b we=%b addr=%h wd=%h ack=%b%b expected all zero",
        busC.mem_en, busC.mem_we, busC.mem_addr, busC.mem_wdata, busC.r0_ack, busC.r1_ack);
    end
  endtask

  task automatic test_cpu_write();
    @(negedge clk);
    busA.r0_we = 4'hF; busA.r0_addr = 11'h010; busA.r0_wdata = 32'hDEADBEEF; busA.r0_req = 1;
    #1;
    compared++;
    if ({busA.r0_stall, busA.mem_en} !== 2'b10) begin
      mismatched++; $display("FAIL wr_cycleN: got stall=%b en=%b expected stall=1 en=0", busA.r0_stall, busA.mem_en);
    end
    @(negedge clk);
    compared++;
    if ({busA.mem_en, busA.mem_we, busA.mem_addr, busA.mem_wdata, busA.r0_ack, busA.r0_stall}
        !== {1'b1, 4'hF, 11'h010, 32'hDEADBEEF, 1'b0, 1'b1}) begin
      mismatched++; $display("FAIL wr_access: got en=%b we=%b addr=%h wd=%h ack=%b stall=%b expected 1 1111 010 deadbeef 0 1",
        busA.mem_en, busA.mem_we, busA.mem_addr, busA.mem_wdata, busA.r0_ack, busA.r0_stall);
    end
    @(negedge clk);
    compared++;
    if ({busA.mem_en, busA.mem_we, busA.r0_ack, busA.r1_ack, busA.r0_stall} !== {1'b0, 4'h0, 1'b1, 1'b0, 1'b0}) begin
      mismatched++; $display("FAIL wr_resp: got en=%b we=%b ack0=%b ack1=%b stall=%b expected 0 0000 1 0 0",
        busA.mem_en, busA.mem_we, busA.r0_ack, busA.r1_ack, busA.r0_stall);
    end
    busA.r0_req = 0; busA.r0_we = 0;
    @(negedge clk);
    compared++;
    if ({busA.r0_ack, busA.mem_en} !== 2'b00) begin
      mismatched++; $display("FAIL wr_after: got ack=%b en=%b expected 0 0", busA.r0_ack, busA.mem_en);
    end
  endtask

  task automatic test_cpu_read();
    @(negedge clk);
    busA.r0_we = 4'h0; busA.r0_addr = 11'h010; busA.r0_wdata = 32'h0; busA.r0_req = 1;
    @(negedge clk);
    compared++;
    if ({busA.mem_en, busA.mem_we, busA.mem_addr, busA.r0_ack} !== {1'b1, 4'h0, 11'h010, 1'b0}) begin
      mismatched++; $display("FAIL rd_access: got en=%b we=%b addr=%h ack=%b expected 1 0000 010 0",
        busA.mem_en, busA.mem_we, busA.mem_addr, busA.r0_ack);
    end
    @(negedge clk);
    compared++;
    if ({busA.r0_ack, busA.mem_we, busA.rdata} !== {1'b1, 4'h0, 32'hDEADBEEF}) begin
      mismatched++; $display("FAIL rd_resp: got ack=%b we=%b rdata=%h expected 1 0000 deadbeef",
        busA.r0_ack, busA.mem_we, busA.rdata);
    end
    busA.r0_req = 0;
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    bit e0, e1, en;
    logic [10:0] ea;
    reset = 1;
    busA.r0_req = 1; busA.r0_we = 0; busA.r0_addr = 11'h020;
    busA.r1_req = 1; busA.r1_we = 0; busA.r1_addr = 11'h030;
    @(negedge clk);
    @(negedge clk);
    reset = 0;
    for (int o = 1; o <= 11; o++) begin
      @(negedge clk);
      en = (o % 3 == 1);
      e0 = (o % 3 == 2) && ((o / 3) % 2 == 0);
      e1 = (o % 3 == 2) && ((o / 3) % 2 == 1);
      compared++;
      if ({busA.r0_ack, busA.r1_ack, busA.mem_en} !== {e0, e1, en}) begin
        mismatched++; $display("FAIL rr_cycle%0d: got ack0=%b ack1=%b en=%b expected %b %b %b",
          o, busA.r0_ack, busA.r1_ack, busA.mem_en, e0, e1, en);
      end
      if (en) begin
        ea = ((o / 3) % 2 == 0) ? 11'h020 : 11'h030;
        compared++;
        if (busA.mem_addr !== ea) begin
          mismatched++; $display("FAIL rr_addr%0d: got %h expected %h", o, busA.mem_addr, ea);
        end
      end
    end
    busA.r0_req = 0; busA.r1_req = 0;
    @(negedge clk);
  endtask

  task automatic test_aux_byte_write();
    logic [31:0] rd;
    int lat, enCnt;
    access_b(1'b1, 4'hF, 11'h7FF, 32'h11223344, rd, lat, enCnt);
    compared++;
    if (lat !== 5 || enCnt !== 1) begin
      mismatched++; $display("FAIL aux_full_wr: got lat=%0d en_cycles=%0d expected 5 1", lat, enCnt);
    end
    access_b(1'b1, 4'b0010, 11'h7FF, 32'h0000AB00, rd, lat, enCnt);
    compared++;
    if (lat !== 5 || enCnt !== 1) begin
      mismatched++; $display("FAIL aux_byte_wr: got lat=%0d en_cycles=%0d expected 5 1", lat, enCnt);
    end
    access_b(1'b0, 4'h0, 11'h7FF, 32'h0, rd, lat, enCnt);
    compared++;
    if (lat !== 5 || rd !== 32'h1122AB44) begin
      mismatched++; $display("FAIL aux_readback: got lat=%0d rdata=%h expected 5 1122ab44", lat, rd);
    end
  endtask

  task automatic test_reset_in_wait();
    bit eAck, eEn;
    @(negedge clk);
    busB.r0_we = 0; busB.r0_addr = 11'h7FF; busB.r0_req = 1;
    @(negedge clk);
    compared++;
    if (busB.mem_en !== 1'b1) begin
      mismatched++; $display("FAIL rw_access: got en=%b expected 1", busB.mem_en);
    end
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    compared++;
    if ({busB.mem_en, busB.mem_we, busB.r0_ack, busB.r1_ack} !== 7'd0) begin
      mismatched++; $display("FAIL rw_after_reset: got en=%b we=%b ack=%b%b expected all zero",
        busB.mem_en, busB.mem_we, busB.r0_ack, busB.r1_ack);
    end
    reset = 0;
    for (int o = 4; o <= 10; o++) begin
      @(negedge clk);
      eEn  = (o == 4);
      eAck = (o == 8);
      compared++;
      if ({busB.r0_ack, busB.r1_ack, busB.mem_en} !== {eAck, 1'b0, eEn}) begin
        mismatched++; $display("FAIL rw_cycle%0d: got ack0=%b ack1=%b en=%b expected %b 0 %b",
          o, busB.r0_ack, busB.r1_ack, busB.mem_en, eAck, eEn);
      end
      if (eAck) begin
        compared++;
        if (busB.rdata !== 32'h1122AB44) begin
          mismatched++; $display("FAIL rw_rdata: got %h expected 1122ab44", busB.rdata);
        end
        busB.r0_req = 0;
      end
    end
  endtask

  task automatic test_fixed_prio();
    bit e0, e1;
    reset = 1;
    busC.r0_req = 1; busC.r0_we = 0; busC.r0_addr = 11'h040;
    busC.r1_req = 1; busC.r1_we = 0; busC.r1_addr = 11'h050;
    @(negedge clk);
    @(negedge clk);
    reset = 0;
    for (int o = 1; o <= 14; o++) begin
      @(negedge clk);
      e0 = (o <= 11) && (o % 3 == 2);
      e1 = (o == 14);
      compared++;
      if ({busC.r0_ack, busC.r1_ack} !== {e0, e1}) begin
        mismatched++; $display("FAIL fp_cycle%0d: got ack0=%b ack1=%b expected %b %b",
          o, busC.r0_ack, busC.r1_ack, e0, e1);
      end
      if (o == 13) begin
        compared++;
        if ({busC.mem_en, busC.mem_addr} !== {1'b1, 11'h050}) begin
          mismatched++; $display("FAIL fp_r1_access: got en=%b addr=%h expected 1 050", busC.mem_en, busC.mem_addr);
        end
      end
      if (o == 11) busC.r0_req = 0;
    end
    busC.r1_req = 0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_cpu_write();
    test_cpu_read();
    test_round_robin();
    test_aux_byte_write();
    test_reset_in_wait();
    test_fixed_prio();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
